// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a valid/ready line port to memory.
// Optional build macro CACHE_STATS_EN adds 32-bit hit_count / miss_count outputs.
module direct_mapped_cache #(
   parameter int NUM_SETS   = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     is_input_valid,
   input  logic [31:0]              addr,
   input  logic                     mem_read,
   input  logic                     mem_write,
   input  logic [31:0]              din,
   output logic                     is_ready,
   output logic                     is_output_valid,
   output logic [31:0]              dout,
   output logic                     is_hit,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   output logic [32*LINE_WORDS-1:0] mem_wdata,
   input  logic                     mem_resp_valid,
   input  logic [32*LINE_WORDS-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
`endif
);

   localparam int W  = $clog2(LINE_WORDS);
   localparam int I  = $clog2(NUM_SETS);
   localparam int TW = 32 - 2 - W - I;
   localparam int LW = 32 * LINE_WORDS;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WB_REQ    = 3'd1;
   localparam logic [2:0] WB_WAIT   = 3'd2;
   localparam logic [2:0] FILL_REQ  = 3'd3;
   localparam logic [2:0] FILL_WAIT = 3'd4;

   logic [2:0]          state;
   logic [2:0]          next_state;
   logic [NUM_SETS-1:0] valid;
   logic [NUM_SETS-1:0] dirty;
   logic [TW-1:0]       tag_mem  [NUM_SETS];
   logic [LW-1:0]       data_mem [NUM_SETS];
   logic [TW-1:0]       miss_tag;
   logic [I-1:0]        miss_index;

   logic [TW-1:0] req_tag;
   logic [I-1:0]  req_index;
   logic [W-1:0]  req_word;
   logic          hit;
   logic          miss;
   logic          fill_done;
   logic          unused_addr_bits;

   assign req_tag          = addr[31 -: TW];
   assign req_index        = addr[2+W +: I];
   assign req_word         = addr[2 +: W];
   assign unused_addr_bits = ^addr[1:0];

   // Request decode; hits answer in the same cycle they are presented.
   always_comb begin
      hit       = 1'b0;
      miss      = 1'b0;
      fill_done = (state == FILL_WAIT) && mem_resp_valid;
      if (is_input_valid && (state == IDLE) && (mem_read || mem_write)) begin
         hit  = valid[req_index] && (tag_mem[req_index] == req_tag);
         miss = !(valid[req_index] && (tag_mem[req_index] == req_tag));
      end else begin
         hit  = 1'b0;
         miss = 1'b0;
      end
   end

   assign is_ready        = (state == IDLE);
   assign is_hit          = hit;
   assign is_output_valid = hit;

   // Load data is forced to zero unless a load actually completes.
   always_comb begin
      dout = 32'd0;
      if (hit && mem_read && !mem_write) begin
         dout = data_mem[req_index][{req_word, 5'd0} +: 32];
      end else begin
         dout = 32'd0;
      end
   end

   // Memory port: address and data come from latched miss state, so they hold while valid is high.
   always_comb begin
      mem_req_valid = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = 32'd0;
      mem_wdata     = '0;
      case (state)
         WB_REQ: begin
            mem_req_valid = 1'b1;
            mem_we        = 1'b1;
            mem_addr      = {tag_mem[miss_index], miss_index, {(W+2){1'b0}}};
            mem_wdata     = data_mem[miss_index];
         end
         FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_addr      = {miss_tag, miss_index, {(W+2){1'b0}}};
         end
         default: begin
            mem_req_valid = 1'b0;
         end
      endcase
   end

   // Miss-handling state machine transitions.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (miss && valid[req_index] && dirty[req_index]) begin
               next_state = WB_REQ;
            end else if (miss) begin
               next_state = FILL_REQ;
            end else begin
               next_state = IDLE;
            end
         end
         WB_REQ:    next_state = mem_req_ready  ? WB_WAIT   : WB_REQ;
         WB_WAIT:   next_state = mem_resp_valid ? FILL_REQ  : WB_WAIT;
         FILL_REQ:  next_state = mem_req_ready  ? FILL_WAIT : FILL_REQ;
         FILL_WAIT: next_state = mem_resp_valid ? IDLE      : FILL_WAIT;
         default:   next_state = IDLE;
      endcase
   end

   // Control state; reset drops valid/dirty so any in-flight victim data is discarded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         valid      <= '0;
         dirty      <= '0;
         miss_tag   <= '0;
         miss_index <= '0;
      end else begin
         state <= next_state;
         if (miss) begin
            miss_tag   <= req_tag;
            miss_index <= req_index;
         end
         if (hit && mem_write) begin
            dirty[req_index] <= 1'b1;
         end
         if (fill_done) begin
            valid[miss_index] <= 1'b1;
            dirty[miss_index] <= 1'b0;
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them.
   always_ff @(posedge clk) begin
      if (hit && mem_write) begin
         data_mem[req_index][{req_word, 5'd0} +: 32] <= din;
      end
      if (fill_done) begin
         data_mem[miss_index] <= mem_rdata;
         tag_mem[miss_index]  <= miss_tag;
      end
   end

`ifdef CACHE_STATS_EN
   logic replay;

   // Statistics; the hit that replays a just-filled miss is not counted again.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
         replay     <= 1'b0;
      end else begin
         replay <= fill_done;
         if (miss) begin
            miss_count <= miss_count + 32'd1;
         end
         if (hit && !replay) begin
            hit_count <= hit_count + 32'd1;
         end
      end
   end
`endif

endmodule
